// File: rtl/parking_pkg.sv
// Shared definitions for the car parking system: state encoding, digit
// width and the default timing constants used by the entry terminal and
// the gate controller.
package parking_pkg;

  // Terminal states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DIGIT1 = 3'd1,
    DIGIT2 = 3'd2,
    SUBMIT = 3'd3,
    LOCKED = 3'd4
  } state_e;

  localparam int DIGIT_W = 2;

  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd50_000_000;
  localparam logic [31:0] DEF_LOCKOUT_CYCLES = 32'd250_000_000;
  localparam logic [1:0]  DEF_MAX_TRIES      = 2'd3;

  // Saturating increment: a 32-bit cycle counter never wraps to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

  // True on the cycle whose count completes 'limit' cycles in a state.
  // Evaluated in 33 bits so a limit of zero or all-ones behaves sanely.
  function automatic logic count_reached(input logic [31:0] cnt,
                                         input logic [31:0] limit);
    return ({1'b0, cnt} + 33'd1) >= {1'b0, limit};
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer for an asynchronous, already-debounced level input,
// plus a history register that yields a single-cycle rising-edge pulse.
module key_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Metastability chain followed by the edge-detect history flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/parking_keypad.sv
// Entry terminal of the parking system: collects a two-digit password while
// a car waits, presents it to the gate controller and reacts to the gate's
// green/red verdict, with a retry limit, lockout and inactivity timeout.
module parking_keypad
  import parking_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [1:0]  MAX_TRIES      = DEF_MAX_TRIES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sensor_entrance,
  input  logic               key_press,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_clear,
  input  logic               gate_green,
  input  logic               gate_red,
  output logic [DIGIT_W-1:0] password_1,
  output logic [DIGIT_W-1:0] password_2,
  output logic               pw_valid,
  output logic [1:0]         digit_count,
  output logic [1:0]         tries,
  output logic               locked
);

  // Synchronized inputs
  logic press_lvl_s, press_rise_s;
  logic clear_lvl_s, clear_rise_s;
  logic sensor_lvl_s, sensor_rise_s;

  // key_digit travels alongside key_press so it is stable at the press edge
  logic [DIGIT_W-1:0] digit_meta_q;
  logic [DIGIT_W-1:0] digit_sync_q;

  // Gate result registers and their history for edge detection
  logic green_q, green_prev_q;
  logic red_q, red_prev_q;
  logic green_rise_s, red_rise_s;

  // FSM, output and counter registers
  state_e             state_q;
  logic [DIGIT_W-1:0] pw1_q;
  logic [DIGIT_W-1:0] pw2_q;
  logic               pw_valid_q;
  logic [1:0]         count_q;
  logic [1:0]         tries_q;
  logic               locked_q;
  logic [31:0]        inact_q;
  logic [31:0]        lock_q;

  // Derived control
  logic [31:0] inact_d;
  logic [31:0] lock_d;
  logic        timeout_s;
  logic        lock_done_s;
  logic        abort_s;
  logic        tries_hit_s;
  logic [1:0]  tries_inc_s;

  // Only the edge of press/clear and the level of the sensor are used
  logic unused_s;
  assign unused_s = ^{press_lvl_s, clear_lvl_s, sensor_rise_s};

  key_sync_edge u_press (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (key_press),
    .level   (press_lvl_s),
    .rise    (press_rise_s)
  );

  key_sync_edge u_clear (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (key_clear),
    .level   (clear_lvl_s),
    .rise    (clear_rise_s)
  );

  key_sync_edge u_sensor (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sensor_entrance),
    .level   (sensor_lvl_s),
    .rise    (sensor_rise_s)
  );

  // Digit synchronizer and one-stage registration of the gate verdict lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_meta_q <= {DIGIT_W{1'b0}};
      digit_sync_q <= {DIGIT_W{1'b0}};
      green_q      <= 1'b0;
      green_prev_q <= 1'b0;
      red_q        <= 1'b0;
      red_prev_q   <= 1'b0;
    end else begin
      digit_meta_q <= key_digit;
      digit_sync_q <= digit_meta_q;
      green_q      <= gate_green;
      green_prev_q <= green_q;
      red_q        <= gate_red;
      red_prev_q   <= red_q;
    end
  end

  assign green_rise_s = green_q & ~green_prev_q;
  assign red_rise_s   = red_q & ~red_prev_q;

  // Counter next values, timeout/lockout detection and retry-limit compare
  always_comb begin
    inact_d     = sat_inc32(inact_q);
    lock_d      = sat_inc32(lock_q);
    timeout_s   = count_reached(inact_q, TIMEOUT_CYCLES);
    lock_done_s = count_reached(lock_q, LOCKOUT_CYCLES);
    abort_s     = timeout_s | ~sensor_lvl_s;
    tries_hit_s = (({1'b0, tries_q} + 3'd1) == {1'b0, MAX_TRIES});
    if (tries_q == 2'd3) begin
      tries_inc_s = tries_q;
    end else begin
      tries_inc_s = tries_q + 2'd1;
    end
  end

  // Terminal FSM with registered outputs, inactivity and lockout counters.
  // Within each state the branch order encodes the event priority:
  // timeout, sensor loss, green, red, clear, press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pw1_q      <= {DIGIT_W{1'b0}};
      pw2_q      <= {DIGIT_W{1'b0}};
      pw_valid_q <= 1'b0;
      count_q    <= 2'd0;
      tries_q    <= 2'd0;
      locked_q   <= 1'b0;
      inact_q    <= 32'd0;
      lock_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          pw1_q      <= {DIGIT_W{1'b0}};
          pw2_q      <= {DIGIT_W{1'b0}};
          pw_valid_q <= 1'b0;
          count_q    <= 2'd0;
          tries_q    <= 2'd0;
          locked_q   <= 1'b0;
          inact_q    <= 32'd0;
          lock_q     <= 32'd0;
          if (sensor_lvl_s) begin
            state_q <= DIGIT1;
          end else begin
            state_q <= IDLE;
          end
        end

        DIGIT1, DIGIT2: begin
          if (abort_s) begin
            state_q    <= IDLE;
            pw1_q      <= {DIGIT_W{1'b0}};
            pw2_q      <= {DIGIT_W{1'b0}};
            pw_valid_q <= 1'b0;
            count_q    <= 2'd0;
            tries_q    <= 2'd0;
            inact_q    <= 32'd0;
          end else if (clear_rise_s) begin
            state_q <= DIGIT1;
            pw1_q   <= {DIGIT_W{1'b0}};
            pw2_q   <= {DIGIT_W{1'b0}};
            count_q <= 2'd0;
            inact_q <= 32'd0;
          end else if (press_rise_s) begin
            inact_q <= 32'd0;
            if (state_q == DIGIT1) begin
              pw1_q   <= digit_sync_q;
              count_q <= 2'd1;
              state_q <= DIGIT2;
            end else begin
              pw2_q      <= digit_sync_q;
              count_q    <= 2'd2;
              pw_valid_q <= 1'b1;
              state_q    <= SUBMIT;
            end
          end else begin
            inact_q <= inact_d;
          end
        end

        SUBMIT: begin
          if (abort_s || green_rise_s) begin
            state_q    <= IDLE;
            pw1_q      <= {DIGIT_W{1'b0}};
            pw2_q      <= {DIGIT_W{1'b0}};
            pw_valid_q <= 1'b0;
            count_q    <= 2'd0;
            tries_q    <= 2'd0;
            inact_q    <= 32'd0;
          end else if (red_rise_s) begin
            pw1_q      <= {DIGIT_W{1'b0}};
            pw2_q      <= {DIGIT_W{1'b0}};
            pw_valid_q <= 1'b0;
            count_q    <= 2'd0;
            inact_q    <= 32'd0;
            if (tries_hit_s) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              lock_q   <= 32'd0;
            end else begin
              state_q <= DIGIT1;
              tries_q <= tries_inc_s;
            end
          end else begin
            inact_q <= inact_d;
          end
        end

        LOCKED: begin
          if (lock_done_s) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            tries_q  <= 2'd0;
            lock_q   <= 32'd0;
            inact_q  <= 32'd0;
          end else begin
            lock_q <= lock_d;
          end
        end

        default: begin
          state_q    <= IDLE;
          pw1_q      <= {DIGIT_W{1'b0}};
          pw2_q      <= {DIGIT_W{1'b0}};
          pw_valid_q <= 1'b0;
          count_q    <= 2'd0;
          tries_q    <= 2'd0;
          locked_q   <= 1'b0;
          inact_q    <= 32'd0;
          lock_q     <= 32'd0;
        end
      endcase
    end
  end

  assign password_1  = pw1_q;
  assign password_2  = pw2_q;
  assign pw_valid    = pw_valid_q;
  assign digit_count = count_q;
  assign tries       = tries_q;
  assign locked      = locked_q;

endmodule
